sll_seq_n: RTL and testbench

- Sequential N-bit logical-left barrel shifter. It is the left-direction counterpart of the team's combinational logical-right shifter and sits in the same ALU datapath.
- It resolves one barrel level per clock: level k applies a shift of 2^k when amount bit k is set.
- It uses a start/busy/done handshake, so the ALU controller can share one registered shift unit across multi-cycle instructions.
- Shift amounts of N or more yield zero, matching the right shifter's overshift semantics.

---
 rtl/sll_seq_n.sv | 90 +++++++++
 tb/tb_sll_seq_n.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sll_seq_n.sv
// Sequential logical-left barrel shifter, one barrel level resolved per clock.
// Latency: L = log2(N) edges from the accepting edge to the done pulse, independent of B.
// Backpressure: start is taken only while idle; requests made while busy are dropped.
module sll_seq_n #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] C
);

    localparam int L  = $clog2(N);
    localparam int CW = $clog2(L + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   data_r;
    logic [N-1:0]   step_dat;
    logic [N-1:0]   c_r;
    logic [L-1:0]   amt_r;
    logic           ovf_r;
    logic [CW-1:0]  cnt;
    logic           done_r;
    logic           amt_bit;
    logic           last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cnt reaches L while idle after an op; the masked select keeps that harmless.
    always_comb begin
        state_nxt = state;
        amt_bit   = |(amt_r & (L'(1) << cnt));
        last      = (state == SHIFT) && (cnt == CW'(L - 1));
        step_dat  = amt_bit ? (data_r << (32'd1 << cnt)) : data_r;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
            amt_r  <= '0;
            ovf_r  <= 1'b0;
            cnt    <= '0;
            c_r    <= '0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        data_r <= A;
                        amt_r  <= B[L-1:0];
                        ovf_r  <= |B[N-1:L];
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    data_r <= step_dat;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        c_r    <= ovf_r ? '0 : step_dat;
                        done_r <= 1'b1;
                    end
                end
                default: done_r <= 1'b0;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = done_r;
    assign C    = c_r;

endmodule

// File: tb/tb_sll_seq_n.sv
// Directed bench for sll_seq_n (N=8): hand-computed vectors plus a golden-model sweep.
module tb_sll_seq_n;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic [7:0] C;

    int checks   = 0;
    int failures = 0;

    sll_seq_n #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .C     (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op from idle, then measure edges until done and check the result.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp,
                         input string tag);
        int lat;
        @(negedge clk);
        start = 1'b1;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = ~a;
        B     = ~b;
        check({tag, "_busy"}, busy, 1);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 3);
        check({tag, "_C"}, C, exp);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int   lat;
        int   npulse;
        logic [7:0] ra, rb, rexp;

        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_C", C, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'hB5, 8'd3, 8'hA8, "b5_sh3");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_C", C, 8'hA8);
            check("hold_done", done, 0);
        end

        do_op(8'hB5, 8'd0,   8'hB5, "sh0");
        do_op(8'hB5, 8'd7,   8'h80, "sh7");
        do_op(8'hB5, 8'd8,   8'h00, "sh8");
        do_op(8'hB5, 8'hFF,  8'h00, "shFF");
        do_op(8'h3C, 8'd4,   8'hC0, "3c_sh4");
        do_op(8'h81, 8'h10,  8'h00, "ovf_hi");

        // Start while busy is ignored.
        @(negedge clk);
        start = 1'b1;
        A     = 8'h0F;
        B     = 8'd1;
        @(negedge clk);
        start = 1'b1;
        A     = 8'hFF;
        B     = 8'd0;
        check("ign_busy", busy, 1);
        @(negedge clk);
        start  = 1'b0;
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) npulse++;
        end
        check("ign_pulses", npulse, 1);
        check("ign_C", C, 8'h1E);

        // Back-to-back: new start accepted while done is high.
        do_op(8'h55, 8'd1, 8'hAA, "pre_b2b");
        @(negedge clk);
        check("b2b_done_hi", done, 1);
        start = 1'b1;
        A     = 8'h01;
        B     = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_done_lo", done, 0);
        check("b2b_busy", busy, 1);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_lat", lat, 3);
        check("b2b_C", C, 8'h04);

        // Asynchronous reset mid-shift.
        @(negedge clk);
        start = 1'b1;
        A     = 8'hFF;
        B     = 8'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_C", C, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        npulse = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) npulse++;
        end
        check("arst_nodone", npulse, 0);
        do_op(8'hFF, 8'd4, 8'hF0, "post_rst");

        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = (i % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            rexp = (rb < 8) ? 8'((16'(ra) << rb) & 16'h00FF) : 8'h00;
            do_op(ra, rb, rexp, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
